// File: rtl/mul_result_fifo_if.sv
// mul_result_fifo_if: bundles the handshake signals of the result FIFO.
//   Multiplier side : prod_in, done_in (in to the FIFO); ack_out (out).
//   Consumer side   : out_data, out_valid, count, full (out); out_ready (in).
//   slave modport   : the FIFO itself.
//   master modport  : the environment (multiplier chain plus consumer).
interface mul_result_fifo_if #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned DEPTH  = 4
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [DATA_W-1:0] prod_in;
   logic              done_in;
   logic              ack_out;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic [CW-1:0]     count;
   logic              full;

   modport slave (
      input  prod_in, done_in, out_ready,
      output ack_out, out_data, out_valid, count, full
   );

   modport master (
      output prod_in, done_in, out_ready,
      input  ack_out, out_data, out_valid, count, full
   );
endinterface

// File: rtl/mul_result_fifo.sv
// mul_result_fifo: downstream result buffer of the three-operand multiplier.
//   Captures prod_in once per done_in pulse, answers with a one-cycle ack_out,
//   and withholds ack_out while the FIFO is full (backpressure).
//   Entries are presented show-ahead on out_data/out_valid; out_ready pops.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-high reset
//   bus   - mul_result_fifo_if.slave (prod_in, done_in, ack_out, out_data,
//           out_valid, out_ready, count, full)
module mul_result_fifo #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned DEPTH  = 4   // power of two, >= 2
) (
   input logic             clk,
   input logic             reset,
   mul_result_fifo_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} state_t;

   state_t            state;
   logic              ack_q;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count_q;
   logic              full_q;
   logic              out_valid_q;
   logic [DATA_W-1:0] out_data_q;

   logic              push;
   logic              pop;
   logic [AW-1:0]     rd_next;
   logic [CW-1:0]     count_next;

   // Capture only from IDLE and only against the registered full flag, so a
   // pop in the same cycle never opens room for a capture.
   always_comb begin
      push       = (state == IDLE) && bus.done_in && !full_q;
      pop        = out_valid_q && bus.out_ready;
      rd_next    = pop ? rd_ptr + AW'(1) : rd_ptr;
      count_next = count_q;
      if (push && !pop)
         count_next = count_q + CW'(1);
      else if (pop && !push)
         count_next = count_q - CW'(1);
   end

   // Capture FSM with registered acknowledge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         ack_q <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (push) begin
                  state <= ACK;
                  ack_q <= 1'b1;
               end
            end
            ACK: begin
               state <= WAIT_LOW;
               ack_q <= 1'b0;
            end
            WAIT_LOW: begin
               ack_q <= 1'b0;
               if (!bus.done_in)
                  state <= IDLE;
            end
            default: begin
               state <= IDLE;
               ack_q <= 1'b0;
            end
         endcase
      end
   end

   // Storage array carries no reset; validity is tracked by count_q.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= bus.prod_in;
   end

   // Pointers, occupancy and the show-ahead output register.
   // When the new head is the entry being written this edge (FIFO empty after
   // any pop), it is taken straight from prod_in since mem is not yet updated.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         rd_ptr      <= rd_next;
         count_q     <= count_next;
         full_q      <= (count_next == CW'(DEPTH));
         out_valid_q <= (count_next != '0);
         if (count_next != '0)
            out_data_q <= (push && (wr_ptr == rd_next)) ? bus.prod_in : mem[rd_next];
      end
   end

   assign bus.ack_out   = ack_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.count     = count_q;
   assign bus.full      = full_q;
endmodule

// File: tb/tb_mul_result_fifo.sv
// tb_mul_result_fifo: self-checking bench for mul_result_fifo.
//   Table-driven vectors, hand-written corner sequences, then randomized
//   traffic compared against a queue-based reference model.
module tb_mul_result_fifo;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned DEPTH  = 4;

   logic clk;
   logic reset;

   mul_result_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dif ();

   mul_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (dif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned checks = 0;
   int unsigned passed = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
   endtask

   // Advance one rising edge, then settle away from it.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      dif.done_in = 1'b0;
      dif.prod_in = '0;
      dif.out_ready = 1'b0;
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   // Offer one result and hold done_in until acknowledged, then drop it long
   // enough for the capture FSM to return to idle.
   task automatic produce(input logic [63:0] v);
      bit got;
      got = 0;
      dif.done_in = 1'b1;
      dif.prod_in = v;
      for (int i = 0; i < 40; i++) begin
         cyc();
         if (dif.ack_out) begin
            got = 1;
            break;
         end
      end
      if (!got) chk("ack_timeout", 64'd0, 64'd1);
      dif.done_in = 1'b0;
      cyc();
      cyc();
   endtask

   // Pop monitor used by the wrap test.
   bit               mon_en = 0;
   logic [63:0]      mon_q[$];
   int unsigned      mon_max = 0;
   always @(posedge clk) begin
      if (mon_en) begin
         if (dif.out_valid && dif.out_ready) mon_q.push_back(dif.out_data);
         if (int'(dif.count) > int'(mon_max)) mon_max = dif.count;
      end
   end

   typedef struct {
      logic        done;
      logic [63:0] prod;
      logic        rdy;
      logic        e_ack;
      logic        e_valid;
      logic [63:0] e_data;
      logic [63:0] e_count;
      logic        e_full;
   } vec_t;

   vec_t tbl[9];

   // Reference model state
   logic [63:0] mq[$];
   logic [63:0] m_last;
   bit          m_can;
   bit          m_inack;
   bit          m_ack;

   initial begin
      automatic logic [63:0] p1   = 64'h0000_0001_0000_0002;
      automatic logic [63:0] ones = '1;
      automatic logic [63:0] xval = 64'hDEAD_BEEF_0123_4567;

      //           done prod  rdy ack val data  cnt full
      tbl[0] = '{1'b1, p1,    1'b0, 1'b1, 1'b1, p1,    64'd1, 1'b0};
      tbl[1] = '{1'b1, p1,    1'b0, 1'b0, 1'b1, p1,    64'd1, 1'b0};
      tbl[2] = '{1'b1, p1,    1'b0, 1'b0, 1'b1, p1,    64'd1, 1'b0};
      tbl[3] = '{1'b0, p1,    1'b0, 1'b0, 1'b1, p1,    64'd1, 1'b0};
      tbl[4] = '{1'b0, p1,    1'b1, 1'b0, 1'b0, p1,    64'd0, 1'b0};
      tbl[5] = '{1'b0, p1,    1'b1, 1'b0, 1'b0, p1,    64'd0, 1'b0};
      tbl[6] = '{1'b1, 64'd7, 1'b1, 1'b1, 1'b1, 64'd7, 64'd1, 1'b0};
      tbl[7] = '{1'b0, 64'd7, 1'b0, 1'b0, 1'b1, 64'd7, 64'd1, 1'b0};
      tbl[8] = '{1'b0, 64'd7, 1'b1, 1'b0, 1'b0, 64'd7, 64'd0, 1'b0};

      // Reset state
      reset = 1'b1;
      dif.done_in = 1'b0;
      dif.prod_in = '0;
      dif.out_ready = 1'b0;
      cyc();
      chk("rst_ack",   dif.ack_out,   0);
      chk("rst_valid", dif.out_valid, 0);
      chk("rst_data",  dif.out_data,  0);
      chk("rst_count", dif.count,     0);
      chk("rst_full",  dif.full,      0);
      reset = 1'b0;
      cyc();

      // Table: single result with done held, drain, empty pops, push of 7
      foreach (tbl[i]) begin
         dif.done_in   = tbl[i].done;
         dif.prod_in   = tbl[i].prod;
         dif.out_ready = tbl[i].rdy;
         cyc();
         chk($sformatf("tbl%0d_ack", i),   dif.ack_out,   tbl[i].e_ack);
         chk($sformatf("tbl%0d_valid", i), dif.out_valid, tbl[i].e_valid);
         chk($sformatf("tbl%0d_data", i),  dif.out_data,  tbl[i].e_data);
         chk($sformatf("tbl%0d_count", i), dif.count,     tbl[i].e_count);
         chk($sformatf("tbl%0d_full", i),  dif.full,      tbl[i].e_full);
      end
      dif.out_ready = 1'b0;
      cyc();

      // Asynchronous reset mid-operation with done_in already high
      produce(64'd11);
      produce(64'd12);
      chk("pre_rst_count", dif.count, 2);
      dif.done_in = 1'b1;
      dif.prod_in = xval;
      #2 reset = 1'b1;
      #1;
      chk("arst_ack",   dif.ack_out,   0);
      chk("arst_valid", dif.out_valid, 0);
      chk("arst_data",  dif.out_data,  0);
      chk("arst_count", dif.count,     0);
      chk("arst_full",  dif.full,      0);
      reset = 1'b0;
      cyc();
      chk("post_rst_ack",   dif.ack_out,  1);
      chk("post_rst_data",  dif.out_data, xval);
      chk("post_rst_count", dif.count,    1);
      cyc();
      chk("post_rst_ack_low", dif.ack_out, 0);
      dif.done_in = 1'b0;
      do_reset();

      // Fill with backpressure
      for (int v = 1; v <= 4; v++) produce(64'(v));
      chk("fill_count", dif.count, 4);
      chk("fill_full",  dif.full,  1);
      dif.done_in = 1'b1;
      dif.prod_in = 64'd5;
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk("bp_ack", dif.ack_out, 0);
      end
      chk("bp_count", dif.count, 4);
      dif.out_ready = 1'b1;
      cyc();
      chk("bp_pop_ack",   dif.ack_out,  0);
      chk("bp_pop_count", dif.count,    3);
      chk("bp_pop_data",  dif.out_data, 2);
      chk("bp_pop_full",  dif.full,     0);
      dif.out_ready = 1'b0;
      cyc();
      chk("bp_cap_ack",   dif.ack_out, 1);
      chk("bp_cap_count", dif.count,   4);
      dif.done_in = 1'b0;
      cyc();
      cyc();
      dif.out_ready = 1'b1;
      for (int v = 2; v <= 5; v++) begin
         chk("drain_valid", dif.out_valid, 1);
         chk("drain_data",  dif.out_data,  64'(v));
         cyc();
      end
      chk("drain_empty", dif.count, 0);
      dif.out_ready = 1'b0;

      // Simultaneous push and pop, all-ones value
      produce(64'd21);
      produce(64'd22);
      chk("sim_pre_count", dif.count, 2);
      dif.out_ready = 1'b1;
      dif.done_in = 1'b1;
      dif.prod_in = ones;
      cyc();
      chk("sim_count", dif.count,    2);
      chk("sim_ack",   dif.ack_out,  1);
      chk("sim_data",  dif.out_data, 64'd22);
      dif.done_in = 1'b0;
      cyc();
      chk("sim_ones_data",  dif.out_data, ones);
      chk("sim_ones_count", dif.count,    1);
      cyc();
      chk("sim_end_count", dif.count,     0);
      chk("sim_end_valid", dif.out_valid, 0);
      chk("sim_end_data",  dif.out_data,  ones);
      dif.out_ready = 1'b0;

      // Pointer wrap: 100..109 through the FIFO
      do_reset();
      mon_q = {};
      mon_max = 0;
      mon_en = 1;
      for (int v = 100; v < 104; v++) produce(64'(v));
      dif.out_ready = 1'b1;
      for (int v = 104; v < 110; v++) produce(64'(v));
      for (int i = 0; i < 20 && dif.count != 0; i++) cyc();
      mon_en = 0;
      dif.out_ready = 1'b0;
      chk("wrap_n", 64'(mon_q.size()), 10);
      for (int i = 0; i < 10; i++) begin
         if (i < mon_q.size()) chk($sformatf("wrap_%0d", i), mon_q[i], 64'(100 + i));
      end
      chk("wrap_max", 64'(mon_max), 4);

      // Randomized traffic against the reference model
      do_reset();
      mq = {};
      m_last = '0;
      m_can = 1;
      m_inack = 0;
      m_ack = 0;
      begin
         automatic bit captured = 0;
         automatic int unsigned low_hold = 0;
         for (int it = 0; it < 300; it++) begin
            automatic bit push, pop;
            if (!dif.done_in) begin
               if (low_hold > 0) low_hold--;
               else if ($urandom_range(1, 0) == 1) begin
                  dif.done_in = 1'b1;
                  dif.prod_in = ($urandom_range(7, 0) == 0) ? ones : {$urandom, $urandom};
                  captured = 0;
               end
            end else if (captured && $urandom_range(2, 0) == 0) begin
               dif.done_in = 1'b0;
               low_hold = 2;
            end
            dif.out_ready = ($urandom_range(3, 0) != 0) && (it % 64 < 40);

            // A result is taken only when the capture side is ready for a
            // new pulse and the FIFO held fewer than DEPTH entries.
            pop  = (mq.size() > 0) && dif.out_ready;
            push = m_can && dif.done_in && (mq.size() < DEPTH);
            if (pop) m_last = mq.pop_front();
            if (push) mq.push_back(dif.prod_in);
            if (m_can) begin
               if (push) begin
                  m_can = 0;
                  m_inack = 1;
               end
            end else if (m_inack) m_inack = 0;
            else if (!dif.done_in) m_can = 1;
            m_ack = push;
            if (push) captured = 1;

            cyc();
            chk("rnd_ack",   dif.ack_out,   m_ack);
            chk("rnd_valid", dif.out_valid, mq.size() > 0);
            chk("rnd_count", dif.count,     64'(mq.size()));
            chk("rnd_full",  dif.full,      mq.size() == DEPTH);
            chk("rnd_data",  dif.out_data,  (mq.size() > 0) ? mq[0] : m_last);
         end
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
